// File: rtl/irq_controller.sv
// irq_controller: two-source interrupt controller between peripheral IRQ lines
// and the CPU.
//   - Latches rising edges on IRQ_RAISE into pending bits (coalescing repeats).
//   - A bus-programmable mask gates which pending sources may request.
//   - Arbitrates by fixed priority (source 0 first) and presents CPU_IRQ plus a
//     handler vector.
//   - Returns a one-cycle IRQ_ACK pulse to the source when the CPU takes it.
//   - One interrupt in service at a time (no nesting).
//
// Ports:
//   CLK, RESET      clock, synchronous active-high reset
//   IRQ_RAISE[1:0]  peripheral lines, rising-edge sensitive
//   IRQ_ACK[1:0]    one-cycle acknowledge to the serviced source
//   CPU_IRQ         level request to the CPU
//   CPU_IRQ_VECTOR  handler address, meaningful while CPU_IRQ=1
//   CPU_IRQ_TAKEN   CPU accepted the request
//   CPU_IRQ_DONE    CPU executed return-from-interrupt
//   BUS_*           register bus:
//                     BASE+0 MASK, BASE+1 PENDING (W1C), BASE+2 STATUS
//                   reads are registered (1-cycle latency).

// Per-source edge detector and pending latch. A rising edge in the same cycle
// as a clear wins, so a fresh edge is never lost.
module irq_src_slot (
  input  logic clk,
  input  logic rst,
  input  logic raise,
  input  logic clr,
  output logic pending
);
  logic raise_q;
  logic rise;

  assign rise = raise & ~raise_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      raise_q <= 1'b0;
      pending <= 1'b0;
    end else begin
      raise_q <= raise;
      pending <= (pending & ~clr) | rise;
    end
  end
endmodule

module irq_controller #(
  parameter logic [7:0] BASE_ADDR  = 8'hF0,
  parameter logic [7:0] VECTOR0    = 8'hFF,
  parameter logic [7:0] VECTOR1    = 8'hFE,
  parameter logic [1:0] MASK_RESET = 2'b11
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] IRQ_RAISE,
  output logic [1:0] IRQ_ACK,
  output logic       CPU_IRQ,
  output logic [7:0] CPU_IRQ_VECTOR,
  input  logic       CPU_IRQ_TAKEN,
  input  logic       CPU_IRQ_DONE,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [7:0] BUS_DATA_IN,
  output logic [7:0] BUS_DATA_OUT
);
  localparam int NUM_SRC = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic                 sel, sel_nxt;
  logic [NUM_SRC-1:0]   mask;
  logic [NUM_SRC-1:0]   pending;
  logic [NUM_SRC-1:0]   clr;
  logic [NUM_SRC-1:0]   ack_nxt;
  logic [NUM_SRC-1:0]   req;
  logic                 wr_mask, wr_pend;
  logic                 take;

  // Only the low two data bits are architected.
  logic unused_bus_hi;
  assign unused_bus_hi = &{1'b0, BUS_DATA_IN[7:2]};

  assign wr_mask = BUS_WE && (BUS_ADDR == BASE_ADDR);
  assign wr_pend = BUS_WE && (BUS_ADDR == BASE_ADDR + 8'd1);
  assign req     = pending & mask;

  // A withdraw (mask[sel] dropped) takes priority over a same-cycle TAKEN.
  assign take    = (state == REQUEST) && CPU_IRQ_TAKEN && mask[sel];
  assign ack_nxt = {take & sel, take & ~sel};
  assign clr     = ack_nxt | (wr_pend ? BUS_DATA_IN[1:0] : 2'b00);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_src_slot u_slot (
      .clk     (CLK),
      .rst     (RESET),
      .raise   (IRQ_RAISE[i]),
      .clr     (clr[i]),
      .pending (pending[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      sel   <= 1'b0;
      mask  <= MASK_RESET;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      if (wr_mask) mask <= BUS_DATA_IN[1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (|req) begin
          sel_nxt   = ~req[0];
          state_nxt = REQUEST;
        end
      end
      REQUEST: begin
        // sel stays latched here; a newly arrived higher-priority source
        // waits until the next pass through IDLE.
        if (!mask[sel])         state_nxt = IDLE;
        else if (CPU_IRQ_TAKEN) state_nxt = SERVICE;
      end
      SERVICE: begin
        if (CPU_IRQ_DONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs registered from the next-state so CPU_IRQ tracks the state that
  // is entered on this edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      CPU_IRQ        <= 1'b0;
      CPU_IRQ_VECTOR <= 8'h00;
      IRQ_ACK        <= 2'b00;
      BUS_DATA_OUT   <= 8'h00;
    end else begin
      CPU_IRQ        <= (state_nxt == REQUEST);
      CPU_IRQ_VECTOR <= (state_nxt == REQUEST) ? (sel_nxt ? VECTOR1 : VECTOR0) : 8'h00;
      IRQ_ACK        <= ack_nxt;
      if (BUS_ADDR == BASE_ADDR)              BUS_DATA_OUT <= {6'b0, mask};
      else if (BUS_ADDR == BASE_ADDR + 8'd1)  BUS_DATA_OUT <= {6'b0, pending};
      else if (BUS_ADDR == BASE_ADDR + 8'd2)  BUS_DATA_OUT <= {5'b0, state, sel};
      else                                    BUS_DATA_OUT <= 8'h00;
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: expected CPU-side outputs and bus read
// data are queued as stimulus is driven and popped when the cycle is sampled.
module tb_irq_controller;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] IRQ_RAISE = 2'b00;
  logic [1:0] IRQ_ACK;
  logic       CPU_IRQ;
  logic [7:0] CPU_IRQ_VECTOR;
  logic       CPU_IRQ_TAKEN = 1'b0;
  logic       CPU_IRQ_DONE = 1'b0;
  logic [7:0] BUS_ADDR = 8'h00;
  logic       BUS_WE = 1'b0;
  logic [7:0] BUS_DATA_IN = 8'h00;
  logic [7:0] BUS_DATA_OUT;

  int checks = 0;
  int failures = 0;

  logic [10:0] out_q[$];
  logic [7:0]  rd_q[$];
  logic [10:0] e;
  logic [7:0]  r;

  irq_controller dut (
    .CLK(CLK), .RESET(RESET), .IRQ_RAISE(IRQ_RAISE), .IRQ_ACK(IRQ_ACK),
    .CPU_IRQ(CPU_IRQ), .CPU_IRQ_VECTOR(CPU_IRQ_VECTOR),
    .CPU_IRQ_TAKEN(CPU_IRQ_TAKEN), .CPU_IRQ_DONE(CPU_IRQ_DONE),
    .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE), .BUS_DATA_IN(BUS_DATA_IN),
    .BUS_DATA_OUT(BUS_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  // Vector is only meaningful while CPU_IRQ=1.
  function automatic logic [10:0] obs();
    return {CPU_IRQ, (CPU_IRQ ? CPU_IRQ_VECTOR : 8'h00), IRQ_ACK};
  endfunction

  function automatic logic [10:0] mk(input logic irq, input logic [7:0] vec, input logic [1:0] ack);
    return {irq, vec, ack};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = a; BUS_WE = 1'b1; BUS_DATA_IN = d;
    tick();
    BUS_WE = 1'b0; BUS_ADDR = 8'h00; BUS_DATA_IN = 8'h00;
  endtask

  task automatic pulse_taken();
    CPU_IRQ_TAKEN = 1'b1; tick(); CPU_IRQ_TAKEN = 1'b0;
  endtask

  task automatic pulse_done();
    CPU_IRQ_DONE = 1'b1; tick(); CPU_IRQ_DONE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; tick(); tick();
    out_q.push_back(mk(1'b0, 8'h00, 2'b00));
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", obs(), e); end
    checks++;
    if (BUS_DATA_OUT !== 8'h00) begin failures++; $display("FAIL reset_bus_out got=%h exp=00", BUS_DATA_OUT); end
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back(i == 0 ? 8'h03 : 8'h00);
      BUS_ADDR = 8'hF0 + 8'(i); tick(); BUS_ADDR = 8'h00;
      r = rd_q.pop_front(); checks++;
      if (BUS_DATA_OUT !== r) begin failures++; $display("FAIL reset_reg%0d got=%h exp=%h", i, BUS_DATA_OUT, r); end
    end
    // TAKEN outside REQUEST is ignored.
    out_q.push_back(mk(1'b0, 8'h00, 2'b00));
    pulse_taken(); tick();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL stray_taken got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_basic();
    IRQ_RAISE = 2'b01;
    out_q.push_back(mk(1'b0, 8'h00, 2'b00));
    out_q.push_back(mk(1'b1, 8'hFF, 2'b00));
    tick(); IRQ_RAISE = 2'b00;
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL basic_lat1 got=%h exp=%h", obs(), e); end
    tick();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL basic_req got=%h exp=%h", obs(), e); end
    out_q.push_back(mk(1'b0, 8'h00, 2'b01));
    out_q.push_back(mk(1'b0, 8'h00, 2'b00));
    pulse_taken();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL basic_ack got=%h exp=%h", obs(), e); end
    tick();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL basic_ack_end got=%h exp=%h", obs(), e); end
    rd_q.push_back(8'h04); // SERVICE, sel 0
    BUS_ADDR = 8'hF2; tick(); BUS_ADDR = 8'h00;
    r = rd_q.pop_front(); checks++;
    if (BUS_DATA_OUT !== r) begin failures++; $display("FAIL basic_status_svc got=%h exp=%h", BUS_DATA_OUT, r); end
    pulse_done();
    rd_q.push_back(8'h00);
    BUS_ADDR = 8'hF2; tick(); BUS_ADDR = 8'h00;
    r = rd_q.pop_front(); checks++;
    if (BUS_DATA_OUT !== r) begin failures++; $display("FAIL basic_status_idle got=%h exp=%h", BUS_DATA_OUT, r); end
  endtask

  task automatic test_both();
    IRQ_RAISE = 2'b11;
    out_q.push_back(mk(1'b1, 8'hFF, 2'b00));
    tick(); IRQ_RAISE = 2'b00; tick();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL both_first got=%h exp=%h", obs(), e); end
    out_q.push_back(mk(1'b0, 8'h00, 2'b01));
    pulse_taken();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL both_ack0 got=%h exp=%h", obs(), e); end
    tick();
    out_q.push_back(mk(1'b0, 8'h00, 2'b00));
    out_q.push_back(mk(1'b1, 8'hFE, 2'b00));
    pulse_done();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL both_done_idle got=%h exp=%h", obs(), e); end
    tick();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL both_second got=%h exp=%h", obs(), e); end
    out_q.push_back(mk(1'b0, 8'h00, 2'b10));
    pulse_taken();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL both_ack1 got=%h exp=%h", obs(), e); end
    tick(); pulse_done(); tick();
  endtask

  task automatic test_mask();
    bus_write(8'hF0, 8'h02);
    IRQ_RAISE = 2'b01; tick(); IRQ_RAISE = 2'b00; tick(); tick();
    out_q.push_back(mk(1'b0, 8'h00, 2'b00));
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL mask_blocked got=%h exp=%h", obs(), e); end
    rd_q.push_back(8'h01);
    BUS_ADDR = 8'hF1; tick(); BUS_ADDR = 8'h00;
    r = rd_q.pop_front(); checks++;
    if (BUS_DATA_OUT !== r) begin failures++; $display("FAIL mask_pending got=%h exp=%h", BUS_DATA_OUT, r); end
    out_q.push_back(mk(1'b1, 8'hFF, 2'b00));
    bus_write(8'hF0, 8'h03); tick();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL mask_enable got=%h exp=%h", obs(), e); end
    pulse_taken(); tick(); pulse_done(); tick();
  endtask

  task automatic test_withdraw();
    IRQ_RAISE = 2'b10;
    out_q.push_back(mk(1'b1, 8'hFE, 2'b00));
    tick(); IRQ_RAISE = 2'b00; tick();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL wd_req got=%h exp=%h", obs(), e); end
    out_q.push_back(mk(1'b1, 8'hFE, 2'b00));
    out_q.push_back(mk(1'b0, 8'h00, 2'b00));
    out_q.push_back(mk(1'b0, 8'h00, 2'b00));
    bus_write(8'hF0, 8'h01);
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL wd_hold got=%h exp=%h", obs(), e); end
    tick();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL wd_drop got=%h exp=%h", obs(), e); end
    tick();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL wd_stay got=%h exp=%h", obs(), e); end
    rd_q.push_back(8'h02);
    BUS_ADDR = 8'hF1; tick(); BUS_ADDR = 8'h00;
    r = rd_q.pop_front(); checks++;
    if (BUS_DATA_OUT !== r) begin failures++; $display("FAIL wd_pending_kept got=%h exp=%h", BUS_DATA_OUT, r); end
    // New edge on source 1 in the same cycle as its W1C: set wins.
    IRQ_RAISE = 2'b10;
    bus_write(8'hF1, 8'h02);
    IRQ_RAISE = 2'b00;
    rd_q.push_back(8'h02);
    BUS_ADDR = 8'hF1; tick(); BUS_ADDR = 8'h00;
    r = rd_q.pop_front(); checks++;
    if (BUS_DATA_OUT !== r) begin failures++; $display("FAIL w1c_vs_edge got=%h exp=%h", BUS_DATA_OUT, r); end
    bus_write(8'hF1, 8'h02);
    rd_q.push_back(8'h00);
    BUS_ADDR = 8'hF1; tick(); BUS_ADDR = 8'h00;
    r = rd_q.pop_front(); checks++;
    if (BUS_DATA_OUT !== r) begin failures++; $display("FAIL w1c_clear got=%h exp=%h", BUS_DATA_OUT, r); end
    bus_write(8'hF0, 8'h03);
    out_q.push_back(mk(1'b0, 8'h00, 2'b00));
    tick(); tick();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL wd_unmask_idle got=%h exp=%h", obs(), e); end
    // Reads outside the register block return 0.
    for (int i = 0; i < 2; i++) begin
      rd_q.push_back(8'h00);
      BUS_ADDR = (i == 0) ? 8'hF3 : 8'h10; tick(); BUS_ADDR = 8'h00;
      r = rd_q.pop_front(); checks++;
      if (BUS_DATA_OUT !== r) begin failures++; $display("FAIL oob_read%0d got=%h exp=%h", i, BUS_DATA_OUT, r); end
    end
  endtask

  task automatic test_coalesce();
    IRQ_RAISE = 2'b01; tick(); IRQ_RAISE = 2'b00; tick();
    pulse_taken(); tick();
    for (int i = 0; i < 3; i++) begin
      IRQ_RAISE = 2'b01; tick(); IRQ_RAISE = 2'b00; tick();
    end
    out_q.push_back(mk(1'b0, 8'h00, 2'b00));
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL co_in_service got=%h exp=%h", obs(), e); end
    out_q.push_back(mk(1'b1, 8'hFF, 2'b00));
    pulse_done(); tick();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL co_rereq got=%h exp=%h", obs(), e); end
    out_q.push_back(mk(1'b0, 8'h00, 2'b01));
    pulse_taken();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL co_ack got=%h exp=%h", obs(), e); end
    tick(); pulse_done();
    out_q.push_back(mk(1'b0, 8'h00, 2'b00));
    tick(); tick(); tick();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL co_no_third got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_reset_service();
    bus_write(8'hF0, 8'h01);
    IRQ_RAISE = 2'b01; tick(); IRQ_RAISE = 2'b00; tick();
    pulse_taken(); tick();
    RESET = 1'b1; tick();
    out_q.push_back(mk(1'b0, 8'h00, 2'b00));
    e = out_q.pop_front(); checks++;
    if ({obs(), CPU_IRQ_VECTOR} !== {e, 8'h00}) begin failures++; $display("FAIL rst_svc_out got=%h exp=%h", obs(), e); end
    RESET = 1'b0;
    pulse_done(); tick();
    rd_q.push_back(8'h03);
    rd_q.push_back(8'h00);
    BUS_ADDR = 8'hF0; tick();
    r = rd_q.pop_front(); checks++;
    if (BUS_DATA_OUT !== r) begin failures++; $display("FAIL rst_svc_mask got=%h exp=%h", BUS_DATA_OUT, r); end
    BUS_ADDR = 8'hF2; tick(); BUS_ADDR = 8'h00;
    r = rd_q.pop_front(); checks++;
    if (BUS_DATA_OUT !== r) begin failures++; $display("FAIL rst_svc_status got=%h exp=%h", BUS_DATA_OUT, r); end
  endtask

  task automatic test_held_through_reset();
    RESET = 1'b1; IRQ_RAISE = 2'b10; tick(); tick();
    RESET = 1'b0;
    out_q.push_back(mk(1'b0, 8'h00, 2'b00));
    out_q.push_back(mk(1'b1, 8'hFE, 2'b00));
    tick();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL held_lat1 got=%h exp=%h", obs(), e); end
    tick();
    e = out_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL held_req got=%h exp=%h", obs(), e); end
    IRQ_RAISE = 2'b00;
    pulse_taken(); tick(); pulse_done(); tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_both();
    test_mask();
    test_withdraw();
    test_coalesce();
    test_reset_service();
    test_held_through_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
